div_stall_unit: RTL and testbench

- Iterative 32-bit MIPS divider for DIV/DIVU, one quotient bit per cycle.
- Sits in the execute stage and drives the E-stage divider stall request (stall_divE) into the hazard unit. It holds the pipeline while busy and releases it in the cycle the HI/LO result becomes valid.
- Honours the exception flush: an annulled divide stops immediately and never writes a result.

---
 rtl/div_stall_unit.sv | 181 ++++++++++++++++++
 tb/tb_div_stall_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_stall_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU in the execute stage.
// Produces one quotient bit per cycle and requests a pipeline stall while
// busy. The result {HI, LO} = {remainder, quotient} is registered and
// presented with a single-cycle ready pulse. An exception flush (annul_i)
// abandons the operation at once and suppresses its ready pulse.
module div_stall_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // Control state
  logic [1:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  // Datapath state: quo starts as |dividend| and fills with quotient bits
  // from the right as the dividend bits shift out of the top.
  logic [WIDTH-1:0]   quo, quo_next;
  logic [WIDTH-1:0]   rem, rem_next;
  logic [WIDTH-1:0]   dvs, dvs_next;
  logic               neg_q, neg_q_next;
  logic               neg_r, neg_r_next;
  logic [2*WIDTH-1:0] result, result_next;

  // Operand magnitudes and sign handling at acceptance
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;
  logic             b_zero;

  // One restoring step
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Operand preparation: magnitudes for signed mode, raw values otherwise
  always_comb begin
    a_neg  = signed_i & a_i[WIDTH-1];
    b_neg  = signed_i & b_i[WIDTH-1];
    a_mag  = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag  = b_neg ? (~b_i + 1'b1) : b_i;
    accept = (state == IDLE) && start_i && !annul_i;
    b_zero = (b_i == '0);
  end

  // Shift-subtract step and final sign correction of the step outputs
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    fits     = !diff[WIDTH];
    rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], fits};
    // Quotient sign follows the XOR of operand signs; remainder follows
    // the dividend. The most-negative / -1 case wraps naturally.
    q_final  = neg_q ? (~quo_step + 1'b1) : quo_step;
    r_final  = neg_r ? (~rem_step + 1'b1) : rem_step;
  end

  // Next-state logic for control, datapath and result register
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    quo_next    = quo;
    rem_next    = rem;
    dvs_next    = dvs;
    neg_q_next  = neg_q;
    neg_r_next  = neg_r;
    result_next = result;

    if (annul_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo_next   = a_mag;
            rem_next   = '0;
            dvs_next   = b_mag;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            cnt_next   = '0;
            if (b_zero) begin
              // Divide by zero: all-ones quotient, dividend as remainder
              result_next = {a_i, {WIDTH{1'b1}}};
              state_next  = DONE;
            end else begin
              state_next = BUSY;
            end
          end
        end
        BUSY: begin
          quo_next = quo_step;
          rem_next = rem_step;
          if (cnt == LAST) begin
            cnt_next    = '0;
            result_next = {r_final, q_final};
            state_next  = DONE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        DONE: begin
          // Always retire; start_i still high here is the same instruction
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      quo   <= quo_next;
      rem   <= rem_next;
      dvs   <= dvs_next;
      neg_q <= neg_q_next;
      neg_r <= neg_r_next;
    end
  end

  // Result register: only written on entry to DONE, untouched by annul
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= result_next;
    end
  end

  // Outputs: stall covers the acceptance cycle and all of BUSY
  always_comb begin
    stall_o  = !annul_i && (((state == IDLE) && start_i) || (state == BUSY));
    ready_o  = (state == DONE) && !annul_i;
    result_o = result;
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Scoreboard bench for div_stall_unit: expected results and latencies are
// queued when a divide is launched and compared when ready_o pulses.
module tb_div_stall_unit;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        sgn   = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        stall;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [63:0] last_exp = '0;

  div_stall_unit #(
    .WIDTH(32),
    .ITER (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .signed_i(sgn),
    .a_i     (a),
    .b_i     (b),
    .annul_i (annul),
    .stall_o (stall),
    .ready_o (ready),
    .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference divide using wide signed arithmetic, MIPS truncating semantics
  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] qv, rv;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'h0, x});
      sy = longint'({32'h0, y});
    end
    q  = sx / sy;
    r  = sx % sy;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Launch one divide, hold start until ready, then confirm no restart
  task automatic run_div(input string tag, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] expv);
    int          stall_cnt;
    int          lat;
    bit          got;
    logic [63:0] e;
    int          el;
    exp_q.push_back(expv);
    lat_q.push_back((bv == 32'h0) ? 1 : 33);
    start = 1'b1;
    sgn   = s;
    a     = av;
    b     = bv;
    #1;
    check({tag, "_stall_accept"}, {63'h0, stall}, 64'h1);
    stall_cnt = 0;
    got       = 1'b0;
    for (int cyc = 0; cyc < 100 && !got; cyc++) begin
      if (stall) stall_cnt++;
      tick();
      if (ready) begin
        got = 1'b1;
        lat = cyc + 1;
        e   = exp_q.pop_front();
        el  = lat_q.pop_front();
        check({tag, "_result"}, result, e);
        check({tag, "_latency"}, 64'(lat), 64'(el));
        check({tag, "_stall_done"}, {63'h0, stall}, 64'h0);
        last_exp = e;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 64'h0, 64'h1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
    end
    check({tag, "_stall_cycles"}, 64'(stall_cnt), (bv == 32'h0) ? 64'd1 : 64'd33);
    // start still high across the DONE->IDLE edge
    tick();
    check({tag, "_ready_one_shot"}, {63'h0, ready}, 64'h0);
    start = 1'b0;
    tick();
    check({tag, "_no_restart"}, {63'h0, stall}, 64'h0);
  endtask

  // Watch for stray ready pulses over a window
  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ready) pulses++;
    end
    check({tag, "_no_ready"}, 64'(pulses), 64'h0);
    check({tag, "_result_hold"}, result, last_exp);
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb;

    tick();
    tick();
    tick();
    check("reset_stall", {63'h0, stall}, 64'h0);
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_result", result, 64'h0);

    // Start in the very first cycle after reset release
    rst = 1'b0;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
    run_div("divu_by0", 1'b0, 32'h1234, 32'h0, 64'h00001234_FFFFFFFF);
    run_div("div_by0", 1'b1, 32'hFFFF_FF00, 32'h0, 64'hFFFFFF00_FFFFFFFF);

    // Annul at T+10: stall drops immediately, no ready, result held
    start = 1'b1;
    sgn   = 1'b0;
    a     = 32'd1000;
    b     = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    annul = 1'b1;
    #1;
    check("annul_stall", {63'h0, stall}, 64'h0);
    check("annul_ready", {63'h0, ready}, 64'h0);
    tick();
    annul = 1'b0;
    start = 1'b0;
    #1;
    check("annul_idle_stall", {63'h0, stall}, 64'h0);
    tick();
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
    expect_quiet("post_annul", 40);

    // Reset at T+20 aborts with all outputs cleared
    start = 1'b1;
    sgn   = 1'b0;
    a     = 32'h5555_5555;
    b     = 32'd3;
    for (int i = 0; i < 20; i++) tick();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    check("midrst_stall", {63'h0, stall}, 64'h0);
    check("midrst_ready", {63'h0, ready}, 64'h0);
    check("midrst_result", result, 64'h0);
    rst      = 1'b0;
    last_exp = '0;
    expect_quiet("post_rst", 40);
    run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF);

    // Random mix against the reference model, back to back
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = 32'($urandom_range(1, 200));
      if ($urandom_range(0, 1) == 1) rb = ~rb + 32'h1;
      if (i == 3) rb = 32'h0;
      run_div("rand", rs, ra, rb, model(rs, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
